// File: rtl/reflet_uart_bm_defs.sv
// Shared constants and FSM encoding for the UART bus master.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package reflet_uart_bm_defs;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_CAP,
        ST_RESP
    } bm_state_t;

    function automatic int addr_bytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/reflet_uart_bm_phy.sv
// Byte-level 8N1 receiver/transmitter with a shared bit-period divider DIV (DIV >= 2).
// Latency: rx_valid/rx_ferr pulse the cycle after the stop sample; tx start bit the cycle after tx_start.
// Backpressure: none on rx; tx_start is ignored while a byte is being shifted out.
module reflet_uart_bm_phy #(
    parameter int DIV = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr,
    input  logic [7:0] tx_byte,
    input  logic       tx_start,
    output logic       tx,
    output logic       tx_done
);

    localparam int CW = $clog2(DIV + 1);

    logic [1:0]    rx_sync;
    logic          rx_s;
    logic          rx_prev;
    logic          rx_busy;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_bit;
    logic [7:0]    rx_sh;

    logic [8:0]    tx_sh;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit;
    logic          tx_busy;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx};
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_s) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= CW'(DIV / 2 - 1);
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= CW'(DIV - 1);
                rx_bit <= rx_bit + 1'b1;
                if (rx_bit == 4'd0) begin
                    // Start bit gone high at mid-bit: treat as a glitch.
                    if (rx_s)
                        rx_busy <= 1'b0;
                end else if (rx_bit <= 4'd8) begin
                    rx_sh <= {rx_s, rx_sh[7:1]};
                end else begin
                    rx_busy <= 1'b0;
                    if (rx_s) begin
                        rx_byte  <= rx_sh;
                        rx_valid <= 1'b1;
                    end else begin
                        rx_ferr <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_sh   <= '0;
            tx_cnt  <= '0;
            tx_bit  <= '0;
            tx_busy <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_busy) begin
                if (tx_start) begin
                    tx_sh   <= {1'b1, tx_byte};
                    tx      <= 1'b0;
                    tx_cnt  <= CW'(DIV - 1);
                    tx_bit  <= '0;
                    tx_busy <= 1'b1;
                end
            end else begin
                // Pulse during the last cycle of the stop bit so the owner can release the frame on time.
                tx_done <= (tx_bit == 4'd9) && (tx_cnt == CW'(1));
                if (tx_cnt != '0) begin
                    tx_cnt <= tx_cnt - 1'b1;
                end else if (tx_bit == 4'd9) begin
                    tx_busy <= 1'b0;
                    tx      <= 1'b1;
                end else begin
                    tx     <= tx_sh[0];
                    tx_sh  <= {1'b1, tx_sh[8:1]};
                    tx_bit <= tx_bit + 1'b1;
                    tx_cnt <= CW'(DIV - 1);
                end
            end
        end
    end

endmodule

// File: rtl/reflet_uart_bus_master.sv
// UART-driven bus initiator: command frame in on rx, one bus cycle, one response byte out on tx.
// Latency: bus_en one cycle after the last frame byte is accepted; response starts right after the bus cycle.
// Backpressure: none; bytes arriving during BUS/CAP/RESP are dropped. REFLET_UART_BM_TIMEOUT_EN drops stalled frames.
module reflet_uart_bus_master
    import reflet_uart_bm_defs::*;
#(
    parameter int base_addr_size = 16,
    parameter int clk_freq       = 1000000,
    parameter int baud           = 9600,
    parameter int timeout_bits   = 40
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx,
    output logic                      tx,
    output logic                      bus_en,
    output logic                      write_en,
    output logic [base_addr_size-1:0] addr,
    output logic [7:0]                data_out,
    input  logic [7:0]                data_in,
    output logic                      busy
);

    localparam int DIV = clk_freq / baud;
    localparam int AB  = addr_bytes(base_addr_size);
    localparam int AW  = AB * 8;
    localparam int BCW = (AB > 1) ? $clog2(AB) : 1;

    logic [7:0]     rx_byte;
    logic           rx_valid;
    logic           rx_ferr;
    logic [7:0]     tx_byte;
    logic           tx_start;
    logic           tx_done;

    bm_state_t      state;
    logic           is_write;
    logic [BCW-1:0] byte_cnt;
    logic [AW-1:0]  addr_sh;
    logic [AW-1:0]  addr_next;

`ifdef REFLET_UART_BM_TIMEOUT_EN
    localparam int TLIM = timeout_bits * DIV;
    localparam int TCW  = $clog2(TLIM + 1);
    logic [TCW-1:0] idle_cnt;
`endif

    reflet_uart_bm_phy #(.DIV(DIV)) u_phy (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr),
        .tx_byte  (tx_byte),
        .tx_start (tx_start),
        .tx       (tx),
        .tx_done  (tx_done)
    );

    assign addr_next = (addr_sh << 8) | AW'(rx_byte);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            is_write <= 1'b0;
            byte_cnt <= '0;
            addr_sh  <= '0;
            addr     <= '0;
            data_out <= '0;
            bus_en   <= 1'b0;
            write_en <= 1'b0;
            busy     <= 1'b0;
            tx_byte  <= '0;
            tx_start <= 1'b0;
`ifdef REFLET_UART_BM_TIMEOUT_EN
            idle_cnt <= '0;
`endif
        end else begin
            bus_en   <= 1'b0;
            write_en <= 1'b0;
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                            is_write <= (rx_byte == CMD_WRITE);
                            state    <= ST_ADDR;
                        end else begin
                            tx_byte  <= RSP_NAK;
                            tx_start <= 1'b1;
                            state    <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_ferr) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (rx_valid) begin
                        addr_sh <= addr_next;
                        if (byte_cnt == BCW'(AB - 1)) begin
                            addr <= addr_next[base_addr_size-1:0];
                            if (is_write) begin
                                state <= ST_DATA;
                            end else begin
                                bus_en <= 1'b1;
                                state  <= ST_BUS;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_ferr) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (rx_valid) begin
                        data_out <= rx_byte;
                        bus_en   <= 1'b1;
                        write_en <= 1'b1;
                        state    <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (is_write) begin
                        tx_byte  <= RSP_ACK;
                        tx_start <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        state <= ST_CAP;
                    end
                end
                ST_CAP: begin
                    tx_byte  <= data_in;
                    tx_start <= 1'b1;
                    state    <= ST_RESP;
                end
                ST_RESP: begin
                    if (tx_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
`ifdef REFLET_UART_BM_TIMEOUT_EN
            // A stalled partial frame is silently abandoned; overrides the case above.
            if ((state == ST_ADDR || state == ST_DATA) && !rx_valid && !rx_ferr) begin
                if (idle_cnt == TCW'(TLIM - 1)) begin
                    idle_cnt <= '0;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_reflet_uart_bus_master.sv
// Directed bench for reflet_uart_bus_master: vector table of frames plus hand-written corner sequences.
module tb_reflet_uart_bus_master;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        tx;
    logic        bus_en;
    logic        write_en;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic [7:0]  data_in;
    logic        busy;

    always #5 clk = ~clk;

    reflet_uart_bus_master #(
        .base_addr_size (16),
        .clk_freq       (1000000),
        .baud           (100000),
        .timeout_bits   (40)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .tx       (tx),
        .bus_en   (bus_en),
        .write_en (write_en),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in),
        .busy     (busy)
    );

    int          tests = 0;
    int          fails = 0;
    int          bus_cnt = 0;
    logic        last_we = 1'b0;
    logic [15:0] last_addr = '0;
    logic [7:0]  last_dat = '0;

    always @(negedge clk) begin
        if (bus_en) begin
            bus_cnt   = bus_cnt + 1;
            last_we   = write_en;
            last_addr = addr;
            last_dat  = data_out;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        rx = stop;
        repeat (DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input int len);
        send_byte(b0, 1'b1);
        if (len > 1) send_byte(b1, 1'b1);
        if (len > 2) send_byte(b2, 1'b1);
        if (len > 3) send_byte(b3, 1'b1);
    endtask

    task automatic recv_tx(output logic [7:0] b, output logic ok);
        int n;
        n  = 0;
        ok = 1'b0;
        b  = '0;
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) return;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        ok = (tx === 1'b1);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  din;
        int          nbus;
        logic        we;
        logic [7:0]  rsp;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] r;
        logic       ok;
        int         b0;
        int         len;
        int         txlow;

        reset   = 1'b1;
        rx      = 1'b1;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset bus_en", bus_en, 0);
        check("reset write_en", write_en, 0);
        check("reset addr", addr, 0);
        check("reset data_out", data_out, 0);
        check("reset busy", busy, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        vecs[0] = '{cmd: 8'h57, a: 16'hFF16, d: 8'hA5, din: 8'h00, nbus: 1, we: 1'b1, rsp: 8'h06};
        vecs[1] = '{cmd: 8'h52, a: 16'h0010, d: 8'h00, din: 8'h3C, nbus: 1, we: 1'b0, rsp: 8'h3C};
        vecs[2] = '{cmd: 8'h41, a: 16'h0000, d: 8'h00, din: 8'h99, nbus: 0, we: 1'b0, rsp: 8'h15};
        vecs[3] = '{cmd: 8'h57, a: 16'h0000, d: 8'h00, din: 8'h00, nbus: 1, we: 1'b1, rsp: 8'h06};
        vecs[4] = '{cmd: 8'h52, a: 16'hFFFF, d: 8'h00, din: 8'hFF, nbus: 1, we: 1'b0, rsp: 8'hFF};

        for (int v = 0; v < 5; v++) begin
            data_in = vecs[v].din;
            len = (vecs[v].cmd == 8'h57) ? 4 : (vecs[v].cmd == 8'h52) ? 3 : 1;
            b0 = bus_cnt;
            fork
                send_frame(vecs[v].cmd, vecs[v].a[15:8], vecs[v].a[7:0], vecs[v].d, len);
                recv_tx(r, ok);
            join
            check($sformatf("v%0d bus count", v), bus_cnt - b0, vecs[v].nbus);
            if (vecs[v].nbus != 0) begin
                check($sformatf("v%0d write_en", v), last_we, vecs[v].we);
                check($sformatf("v%0d addr", v), last_addr, vecs[v].a);
                if (vecs[v].we) check($sformatf("v%0d data_out", v), last_dat, vecs[v].d);
            end
            check($sformatf("v%0d rsp framed", v), ok, 1);
            check($sformatf("v%0d rsp byte", v), r, vecs[v].rsp);
            repeat (DIV) @(negedge clk);
            check($sformatf("v%0d busy after", v), busy, 0);
            repeat (5) @(negedge clk);
        end

        // Framing error on the last address byte: frame dropped silently.
        b0 = bus_cnt;
        send_byte(8'h52, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        txlow = 0;
        repeat (30 * DIV) begin
            @(negedge clk);
            if (tx !== 1'b1) txlow++;
        end
        check("ferr tx idle", txlow, 0);
        check("ferr bus count", bus_cnt - b0, 0);
        check("ferr busy", busy, 0);
        data_in = 8'h5A;
        fork
            send_frame(8'h52, 8'h12, 8'h34, 8'h00, 3);
            recv_tx(r, ok);
        join
        check("post-ferr bus count", bus_cnt - b0, 1);
        check("post-ferr addr", last_addr, 16'h1234);
        check("post-ferr rsp", r, 8'h5A);
        repeat (DIV + 5) @(negedge clk);

        // Reset in the middle of the first response data bit.
        data_in = 8'hAB;
        fork
            send_frame(8'h52, 8'h00, 8'h10, 8'h00, 3);
            begin
                int n;
                n = 0;
                while (tx !== 1'b0 && n < 3000) begin
                    @(negedge clk);
                    n++;
                end
                check("rst tx started", tx, 0);
                repeat (DIV + DIV / 2) @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                check("rst tx", tx, 1);
                check("rst busy", busy, 0);
                check("rst bus_en", bus_en, 0);
                check("rst addr", addr, 0);
                reset = 1'b0;
            end
        join
        repeat (2 * DIV) @(negedge clk);
        b0 = bus_cnt;
        fork
            send_frame(8'h57, 8'hFF, 8'h16, 8'hA5, 4);
            recv_tx(r, ok);
        join
        check("post-rst bus count", bus_cnt - b0, 1);
        check("post-rst addr", last_addr, 16'hFF16);
        check("post-rst data", last_dat, 8'hA5);
        check("post-rst rsp", r, 8'h06);
        repeat (DIV + 5) @(negedge clk);

        // Partial frame followed by a long idle gap.
        b0 = bus_cnt;
        send_byte(8'h57, 1'b1);
        send_byte(8'h12, 1'b1);
        repeat (40 * DIV + 50) @(negedge clk);
`ifdef REFLET_UART_BM_TIMEOUT_EN
        check("timeout busy", busy, 0);
        check("timeout bus count", bus_cnt - b0, 0);
`else
        check("no-timeout busy", busy, 1);
        fork
            begin
                send_byte(8'h34, 1'b1);
                send_byte(8'hAA, 1'b1);
            end
            recv_tx(r, ok);
        join
        check("no-timeout bus count", bus_cnt - b0, 1);
        check("no-timeout addr", last_addr, 16'h1234);
        check("no-timeout data", last_dat, 8'hAA);
        check("no-timeout rsp", r, 8'h06);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
